fifo_64to8_unpack: RTL and testbench
====================================

Name: fifo_64to8_unpack

Overview:
- Width down-converter, the mirror of the 8-to-64 byte packer: accepts 64-bit words on a valid/ready interface and emits them one byte per cycle on an 8-bit valid/ready interface.
- Contains a DEPTH-word buffer FIFO feeding a shift-out stage.
- Runs on a single clock.
- Sits between a 64-bit producer (packed-word source or memory reader) and a byte-wide consumer.

Parameters:
- DEPTH, 4, word FIFO depth in 64-bit entries; power of two, 2..16.
- MSB_FIRST, 1, 1: byte order is in_data[63:56] first; 0: in_data[7:0] first.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_data  input  64  packed word.
- in_ready  output  1  FIFO can accept a word; registered, equals !full.
- out_valid  output  1  out_data holds a byte.
- out_data  output  8  current byte.
- out_last  output  1  high with the 8th byte of a word.
- out_ready  input  1  consumer accepts the byte.
- level  output  $clog2(DEPTH)+1  words held in the FIFO, excluding the word in the shift stage.
- empty  output  1  level == 0.

Behaviour:
- Reset values, applied synchronously while rst is high:
  - in_ready=1, out_valid=0, out_data=0, out_last=0, level=0, empty=1.
  - Write and read pointers are 0, the byte counter is 0, and the shift stage is IDLE.
  - Words already in the FIFO or in the shift stage are discarded. Reset mid-word truncates that word with no further bytes.
- Input handshake:
  - A word is written on any edge where in_valid && in_ready.
  - in_ready is computed from the registered count, so there is no write-through-when-full. When full, a same-cycle read does not enable a write; in_ready rises on the next cycle.
  - in_data is ignored when in_valid=0.
- Word FIFO:
  - Binary pointers of width $clog2(DEPTH), wrapping at DEPTH.
  - level increments on write-only, decrements on read-only, and is unchanged on simultaneous write and read.
- Shift stage, two states:
  - IDLE: out_valid=0. If the FIFO is non-empty, pop one word into the 64-bit shift register, set byte_cnt=0, and go to SHIFT.
  - SHIFT: out_valid=1. out_data = shreg[63:56] when MSB_FIRST=1, or shreg[7:0] when MSB_FIRST=0. out_last = (byte_cnt==7).
    - On out_ready with byte_cnt<7: shift by 8 and increment byte_cnt.
    - On out_ready with byte_cnt==7:
      - If the FIFO is non-empty, pop the next word in the same cycle and stay in SHIFT with byte_cnt=0. There is no bubble, so sustained throughput is 1 byte/cycle.
      - Otherwise go to IDLE.
    - Without out_ready: hold out_data, out_last and byte_cnt stable. This is an AXI-style rule: valid never drops without a handshake.
- Latency: a word accepted at edge k is popped at edge k+1 if the stage is IDLE. Its first byte is visible from edge k+1, i.e. 2 cycles from input to output when empty.
- Simultaneous events:
  - A write to an empty FIFO and a pop on the same edge are not possible (the pop sees the registered empty). The word appears at the next edge.
  - A write and a pop on the same edge at any other level are both performed.
- Ordering: words leave in arrival order, and each word's bytes leave in MSB_FIRST order. Exactly 8 bytes are emitted per word.

Test Plan:
- Reset: hold rst=1 for 3 cycles while in_valid=1 -> in_ready=1, out_valid=0, level=0, empty=1 throughout; nothing is written.
- Single word: in_data=64'h0011_2233_4455_6677, out_ready=1, MSB_FIRST=1 -> first byte 8'h00 appears 2 cycles after acceptance. Bytes 00,11,22,33,44,55,66,77 follow on consecutive cycles; out_last is high only with 8'h77; the stage returns to IDLE.
- Back-to-back, MSB_FIRST=0: 4 consecutive words 64'h0706050403020100 + n·64'h0808080808080808 (n=0..3) -> 32 contiguous bytes 0x00..0x1F with no idle cycle; out_last on 0x07, 0x0F, 0x17, 0x1F.
- Full/backpressure: out_ready=0 while writing 6 words, DEPTH=4 -> 1 word in the shift stage plus 4 in the FIFO. in_ready drops after the 5th accept, level=4, the 6th word is held by the source. Raising out_ready drains all 6 words in order.
- Random stall: out_ready random at 50%, 100 random words -> the byte stream matches the scoreboard exactly. out_data and out_last stay stable on every cycle with out_valid && !out_ready.
- Mid-word reset: assert rst after the 3rd byte of a word with 2 words queued -> the next cycle has out_valid=0 and level=0. A new word after reset starts at its byte 0.

Source files
------------

// File: rtl/fifo_64to8_unpack.sv
// Width down-converter: buffers 64-bit words in a small FIFO and shifts each one out
// a byte per cycle on a valid/ready stream, with no bubble between consecutive words.
module fifo_64to8_unpack #(
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  input  logic [63:0]              in_data_i,
  output logic                     in_ready_o,
  output logic                     out_valid_o,
  output logic [7:0]               out_data_o,
  output logic                     out_last_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {StIdle, StShift} state_e;

  logic [63:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            in_ready_q;
  state_e          state_q;
  logic [63:0]     shreg_q;
  logic [2:0]      byte_cnt_q;

  logic push, pop, fifo_empty, last_byte;

  always_comb begin
    fifo_empty = (count_q == '0);
    last_byte  = (byte_cnt_q == 3'd7);
    push       = in_valid_i && in_ready_q;
    // Refill either from idle or on the final byte handshake, so words run back to back.
    pop        = !fifo_empty && ((state_q == StIdle) || (out_ready_i && last_byte));
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q    <= count_d;
      in_ready_q <= (count_d != CntW'(DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      byte_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            shreg_q    <= mem_q[rd_ptr_q];
            byte_cnt_q <= '0;
            state_q    <= StShift;
          end
        end
        StShift: begin
          if (out_ready_i) begin
            if (!last_byte) begin
              shreg_q    <= MSB_FIRST ? {shreg_q[55:0], 8'h00} : {8'h00, shreg_q[63:8]};
              byte_cnt_q <= byte_cnt_q + 3'd1;
            end else if (pop) begin
              shreg_q    <= mem_q[rd_ptr_q];
              byte_cnt_q <= '0;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q == StShift);
  assign out_data_o  = MSB_FIRST ? shreg_q[63:56] : shreg_q[7:0];
  assign out_last_o  = (state_q == StShift) && last_byte;
  assign level_o     = count_q;
  assign empty_o     = fifo_empty;

endmodule

// File: tb/tb_fifo_64to8_unpack.sv
// Bench for fifo_64to8_unpack: an MSB-first and an LSB-first instance share one stimulus,
// with directed checks plus a byte scoreboard per instance.
module tb_fifo_64to8_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_last, a_empty;
  logic [7:0]  a_out_data;
  logic [2:0]  a_level;
  logic        b_in_ready, b_out_valid, b_out_last, b_empty;
  logic [7:0]  b_out_data;
  logic [2:0]  b_level;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] qa[$];
  logic [8:0] qb[$];

  always #5 clk = ~clk;

  fifo_64to8_unpack #(.DEPTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (a_in_ready),
    .out_valid_o(a_out_valid),
    .out_data_o (a_out_data),
    .out_last_o (a_out_last),
    .out_ready_i(out_ready),
    .level_o    (a_level),
    .empty_o    (a_empty)
  );

  fifo_64to8_unpack #(.DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (b_in_ready),
    .out_valid_o(b_out_valid),
    .out_data_o (b_out_data),
    .out_last_o (b_out_last),
    .out_ready_i(out_ready),
    .level_o    (b_level),
    .empty_o    (b_empty)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: sampled on the falling edge, mid-cycle, where inputs and outputs are settled.
  logic       stall_q = 1'b0;
  logic [7:0] stall_a_data, stall_b_data;
  logic       stall_a_last;

  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check_eq("stall_valid", a_out_valid, 1'b1);
        check_eq("stall_data_a", a_out_data, stall_a_data);
        check_eq("stall_data_b", b_out_data, stall_b_data);
        check_eq("stall_last_a", a_out_last, stall_a_last);
      end
      if (in_valid && a_in_ready) begin
        for (int j = 0; j < 8; j++) begin
          qa.push_back({j == 7, in_data[63-8*j -: 8]});
          qb.push_back({j == 7, in_data[8*j +: 8]});
        end
      end
      if (a_out_valid && out_ready) begin
        check_eq("sb_nonempty_a", qa.size() != 0, 1'b1);
        if (qa.size() != 0) check_eq("sb_byte_a", {a_out_last, a_out_data}, qa.pop_front());
      end
      if (b_out_valid && out_ready) begin
        check_eq("sb_nonempty_b", qb.size() != 0, 1'b1);
        if (qb.size() != 0) check_eq("sb_byte_b", {b_out_last, b_out_data}, qb.pop_front());
      end
      stall_q      = a_out_valid && !out_ready;
      stall_a_data = a_out_data;
      stall_b_data = b_out_data;
      stall_a_last = a_out_last;
    end
  end

  task automatic drain(input string tag, input int budget);
    out_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (!a_out_valid && a_empty) break;
      step();
    end
    check_eq({tag, "_idle"}, {a_out_valid, a_empty}, 2'b01);
    check_eq({tag, "_sb_empty"}, qa.size() + qb.size(), 0);
  endtask

  function automatic logic [63:0] full_word(input int n);
    return 64'h1011_1213_1415_1617 + 64'h1010_1010_1010_1010 * 64'(n);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    int  accepted;
    bit  acc;

    // Reset held with in_valid high: nothing may be written.
    rst = 1'b1; in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0BAD_F00D; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_in_ready", a_in_ready, 1'b1);
      check_eq("rst_out_valid", {a_out_valid, b_out_valid}, 2'b00);
      check_eq("rst_out_data", a_out_data, 8'h00);
      check_eq("rst_out_last", a_out_last, 1'b0);
      check_eq("rst_level", a_level, 3'd0);
      check_eq("rst_empty", a_empty, 1'b1);
    end
    rst = 1'b0; in_valid = 1'b0;
    step();
    check_eq("post_rst_level", a_level, 3'd0);
    check_eq("post_rst_valid", a_out_valid, 1'b0);

    // Single word, latency and byte order.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h0011_2233_4455_6677;
    step();
    in_valid = 1'b0;
    check_eq("single_lat_k", a_out_valid, 1'b0);
    check_eq("single_level_k", a_level, 3'd1);
    step();
    check_eq("single_lat_k1", a_out_valid, 1'b1);
    check_eq("single_first_a", a_out_data, 8'h00);
    check_eq("single_first_b", b_out_data, 8'h77);
    check_eq("single_level_k1", a_level, 3'd0);
    for (int j = 1; j < 8; j++) begin
      step();
      check_eq("single_byte_a", a_out_data, 8'(8'h11 * j));
      check_eq("single_last_a", a_out_last, j == 7);
    end
    step();
    check_eq("single_idle", a_out_valid, 1'b0);

    // Back-to-back: preload four words, then expect 32 bytes with no gap.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 64'h0706_0504_0302_0100 + 64'h0808_0808_0808_0808 * 64'(k);
      step();
    end
    in_valid = 1'b0;
    check_eq("b2b_level", a_level, 3'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check_eq("b2b_valid", {a_out_valid, b_out_valid}, 2'b11);
      check_eq("b2b_data_b", b_out_data, 8'(i));
      check_eq("b2b_last_b", b_out_last, (i % 8) == 7);
      check_eq("b2b_data_a", a_out_data, 8'((i / 8) * 8 + 7 - (i % 8)));
      step();
    end
    check_eq("b2b_idle", a_out_valid, 1'b0);
    check_eq("b2b_empty", a_empty, 1'b1);

    // Full and backpressure.
    out_ready = 1'b0; n = 0;
    for (int i = 0; i < 20 && n < 5; i++) begin
      in_valid = 1'b1;
      in_data  = full_word(n);
      acc      = a_in_ready;
      step();
      if (acc) n++;
    end
    check_eq("full_accepts", n, 5);
    in_data = full_word(5);
    check_eq("full_in_ready", a_in_ready, 1'b0);
    check_eq("full_level", a_level, 3'd4);
    check_eq("full_empty", a_empty, 1'b0);
    step();
    step();
    check_eq("full_hold_ready", a_in_ready, 1'b0);
    check_eq("full_hold_level", a_level, 3'd4);
    check_eq("full_hold_byte", a_out_data, 8'h10);
    out_ready = 1'b1; accepted = 0;
    for (int i = 0; i < 40 && accepted == 0; i++) begin
      acc = in_valid && a_in_ready;
      step();
      if (acc) begin
        accepted = 1;
        in_valid = 1'b0;
      end
    end
    check_eq("full_sixth_accepted", accepted, 1);
    drain("full_drain", 100);

    // Random stalls against the scoreboard.
    accepted = 0;
    for (int cyc = 0; cyc < 6000 && accepted < 100; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom};
      end
      acc = in_valid && a_in_ready;
      step();
      if (acc) begin
        accepted++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check_eq("rand_accepted", accepted, 100);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!a_out_valid && a_empty) break;
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    drain("rand_drain", 10);

    // Mid-word reset with two words queued.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = full_word(k);
      step();
    end
    in_valid = 1'b0;
    step();
    check_eq("mwr_level", a_level, 3'd2);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check_eq("mwr_fourth_byte", a_out_data, 8'h13);
    out_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mwr_valid", {a_out_valid, b_out_valid}, 2'b00);
    check_eq("mwr_level0", a_level, 3'd0);
    check_eq("mwr_empty", a_empty, 1'b1);
    in_valid = 1'b1; in_data = 64'hCAFE_F00D_1234_5678;
    step();
    in_valid = 1'b0;
    step();
    check_eq("mwr_new_valid", a_out_valid, 1'b1);
    check_eq("mwr_new_first_a", a_out_data, 8'hCA);
    check_eq("mwr_new_first_b", b_out_data, 8'h78);
    drain("mwr_drain", 40);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
